execute_pipelined: RTL

Parametrised EX stage for the pipelined LEGv8 core. It takes ID/EX operands, resolves forwarding, and computes the ALU result, flags and branch target. Results are registered into the EX/MEM boundary with a valid bit. Single-cycle ops complete in one clock. MUL runs as an iterative shift-add over WIDTH clocks and stalls upstream while it runs.

---
 rtl/execute_pipelined.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/execute_pipelined.sv
// -----------------------------------------------------------------------------
// execute_pipelined
//
// EX stage of the pipelined LEGv8 core. Resolves operand forwarding, computes
// the ALU result, NZCV flags and branch target, and registers everything into
// the EX/MEM boundary with a one-cycle valid pulse. MUL is an iterative
// shift-add taking WIDTH clocks, during which stall holds the upstream stages.
//
// Ports
//   clk, reset, flush            clock, sync active-high reset, sync flush
//   inValid                      ID/EX holds a valid op
//   ALUReadData1/ALUReadData2    register operands A / B
//   MemForwardData/WbForwardData forwarding sources
//   ForwardA/ForwardB            operand select (00 reg, 10 mem, 01 wb, 11 reg)
//   Immediate, PC, Opcode        sign-extended immediate, op PC, R-type opcode
//   ALUSrc, ALUOp                second-input select, ALU operation class
//   stall                        high while MUL iterates (state only)
//   outValid                     one-cycle pulse per completed op
//   ALUResult, AddResult         result, PC + (Immediate << BRANCH_SHIFT)
//   StoreData, zero, flags       forwarded B, result==0, {N,Z,C,V}
// -----------------------------------------------------------------------------
module execute_pipelined #(
  parameter int WIDTH        = 64,
  parameter int OPCODE_WIDTH = 11,
  parameter int BRANCH_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    inValid,
  input  logic [WIDTH-1:0]        ALUReadData1,
  input  logic [WIDTH-1:0]        ALUReadData2,
  input  logic [WIDTH-1:0]        MemForwardData,
  input  logic [WIDTH-1:0]        WbForwardData,
  input  logic [1:0]              ForwardA,
  input  logic [1:0]              ForwardB,
  input  logic [WIDTH-1:0]        Immediate,
  input  logic [WIDTH-1:0]        PC,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic                    ALUSrc,
  input  logic [1:0]              ALUOp,
  output logic                    stall,
  output logic                    outValid,
  output logic [WIDTH-1:0]        ALUResult,
  output logic [WIDTH-1:0]        AddResult,
  output logic [WIDTH-1:0]        StoreData,
  output logic                    zero,
  output logic [3:0]              flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(11'b10001011000);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(11'b11001011000);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(11'b10001010000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORR = OPCODE_WIDTH'(11'b10101010000);
  localparam logic [OPCODE_WIDTH-1:0] OP_EOR = OPCODE_WIDTH'(11'b11001010000);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(11'b10011011000);

  logic [0:0]       state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] alu_result_reg;
  logic [WIDTH-1:0] add_result_reg;
  logic [WIDTH-1:0] store_data_reg;
  logic             zero_reg;
  logic [3:0]       flags_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] add_target;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] res_next;
  logic             c_next;
  logic             v_next;
  logic             is_mul;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count_next;

  // Forwarding muxes; code 11 falls back to the register value.
  always_comb begin
    case (ForwardA)
      2'b10:   op_a = MemForwardData;
      2'b01:   op_a = WbForwardData;
      default: op_a = ALUReadData1;
    endcase
    case (ForwardB)
      2'b10:   op_b = MemForwardData;
      2'b01:   op_b = WbForwardData;
      default: op_b = ALUReadData2;
    endcase
  end

  assign alu_b      = ALUSrc ? Immediate : op_b;
  assign add_target = PC + (Immediate << BRANCH_SHIFT);

  // SUB as A + ~B + 1 so the carry-out is directly the NOT-borrow flag.
  assign sum_w  = {1'b0, op_a} + {1'b0, alu_b};
  assign diff_w = {1'b0, op_a} + {1'b0, ~alu_b} + (WIDTH+1)'(1);

  always_comb begin
    res_next = '0;
    c_next   = 1'b0;
    v_next   = 1'b0;
    is_mul   = 1'b0;
    case (ALUOp)
      2'b00: begin
        res_next = sum_w[WIDTH-1:0];
        c_next   = sum_w[WIDTH];
        v_next   = (op_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                   (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b01: res_next = alu_b;
      2'b10: begin
        case (Opcode)
          OP_ADD: begin
            res_next = sum_w[WIDTH-1:0];
            c_next   = sum_w[WIDTH];
            v_next   = (op_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                       (sum_w[WIDTH-1] != op_a[WIDTH-1]);
          end
          OP_SUB: begin
            res_next = diff_w[WIDTH-1:0];
            c_next   = diff_w[WIDTH];
            v_next   = (op_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                       (diff_w[WIDTH-1] != op_a[WIDTH-1]);
          end
          OP_AND:  res_next = op_a & alu_b;
          OP_ORR:  res_next = op_a | alu_b;
          OP_EOR:  res_next = op_a ^ alu_b;
          OP_MUL:  is_mul   = 1'b1;
          default: res_next = '0;
        endcase
      end
      default: res_next = '0;
    endcase
  end

  // One shift-add step of the multiplier.
  assign acc_next   = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign count_next = count_reg + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      out_valid_reg  <= 1'b0;
      alu_result_reg <= '0;
      add_result_reg <= '0;
      store_data_reg <= '0;
      zero_reg       <= 1'b0;
      flags_reg      <= 4'b0000;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      count_reg      <= '0;
    end else if (flush) begin
      // Drop any presented op and abort a running MUL; data outputs hold.
      out_valid_reg <= 1'b0;
      state_reg     <= IDLE;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (inValid) begin
            add_result_reg <= add_target;
            store_data_reg <= op_b;
            if (is_mul) begin
              mcand_reg  <= op_a;
              mplier_reg <= alu_b;
              acc_reg    <= '0;
              count_reg  <= '0;
              state_reg  <= BUSY;
            end else begin
              alu_result_reg <= res_next;
              zero_reg       <= (res_next == '0);
              flags_reg      <= {res_next[WIDTH-1], (res_next == '0), c_next, v_next};
              out_valid_reg  <= 1'b1;
            end
          end
        end
        default: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_next;
          if (count_next == CW'(WIDTH)) begin
            alu_result_reg <= acc_next;
            zero_reg       <= (acc_next == '0);
            flags_reg      <= {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
            out_valid_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
      endcase
    end
  end

  assign stall     = (state_reg == BUSY);
  assign outValid  = out_valid_reg;
  assign ALUResult = alu_result_reg;
  assign AddResult = add_result_reg;
  assign StoreData = store_data_reg;
  assign zero      = zero_reg;
  assign flags     = flags_reg;

endmodule
